// File: rtl/framebuffer_nscan.sv
// Double-buffered HUB75 framebuffer with N_SCAN_GROUPS parallel row groups.
// The writer fills the back buffer; the scanner reads bit-planes of the front
// buffer through a 2-cycle registered pipeline. A buffer swap is requested
// with swap_req and takes effect only on a scanner frame boundary.

// One row-group bank: simple dual-port RAM with registered read.
module framebuffer_nscan_bank #(
  parameter int AW = 1,
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2**AW];

  // Write port plus registered read port; the two ports always address
  // different buffers, so no read-during-write collision is possible.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

module framebuffer_nscan #(
  parameter  int N_ROWS_MAX    = 64,
  parameter  int N_COLS_MAX    = 256,
  parameter  int BITDEPTH_MAX  = 8,
  parameter  int N_SCAN_GROUPS = 2,
  localparam int MEM_DEPTH     = N_ROWS_MAX * N_COLS_MAX,
  localparam int W_ADDR_WIDTH  = $clog2(MEM_DEPTH),
  localparam int G_WIDTH       = (N_SCAN_GROUPS > 1) ? $clog2(N_SCAN_GROUPS) : 0,
  localparam int R_ADDR_WIDTH  = W_ADDR_WIDTH - G_WIDTH,
  localparam int BD_WIDTH      = $clog2(BITDEPTH_MAX + 1),
  localparam int RB_WIDTH      = (BITDEPTH_MAX > 1) ? $clog2(BITDEPTH_MAX) : 1,
  localparam int PIX_W         = 3 * BITDEPTH_MAX
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w_en,
  input  logic [W_ADDR_WIDTH-1:0]    w_addr,
  input  logic [PIX_W-1:0]           w_din,
  input  logic                       swap_req,
  output logic                       swap_pending,
  output logic                       swap_done,
  output logic                       front_buffer,
  input  logic [BD_WIDTH-1:0]        ctrl_bitdepth,
  input  logic                       r_en,
  input  logic [R_ADDR_WIDTH-1:0]    r_addr,
  input  logic [RB_WIDTH-1:0]        r_bit,
  input  logic                       r_frame_end,
  output logic                       r_valid,
  output logic [3*N_SCAN_GROUPS-1:0] r_dout
);
  localparam int IDX_W = $clog2(PIX_W);

  typedef enum logic {S_IDLE, S_PEND} state_t;

  state_t                                 r_state, w_state_nxt;
  logic                                   w_do_swap;
  logic                                   r_front;
  logic                                   r_swap_done;
  logic [2:1]                             r_vld_pipe;
  logic [BD_WIDTH-1:0]                    w_bd_eff, r_bd_p1;
  logic [RB_WIDTH-1:0]                    r_bit_p1;
  logic                                   w_kill;
  logic [IDX_W-1:0]                       w_off_b, w_off_g, w_off_r;
  logic [W_ADDR_WIDTH-1:0]                w_wbank;
  logic [N_SCAN_GROUPS-1:0][PIX_W-1:0]    w_rdata;
  logic [3*N_SCAN_GROUPS-1:0]             w_sel, r_dout_q;

  // Swap FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Swap FSM next state: a request waits in PENDING until a frame boundary;
  // further requests while pending are absorbed.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (swap_req && !r_frame_end) w_state_nxt = S_PEND;
      S_PEND:  if (r_frame_end)              w_state_nxt = S_IDLE;
      default:                               w_state_nxt = S_IDLE;
    endcase
  end

  // Swap FSM outputs: pending flag and the swap strobe for this cycle.
  always_comb begin
    swap_pending = (r_state == S_PEND);
    w_do_swap    = r_frame_end && ((r_state == S_PEND) || swap_req);
  end

  // Front buffer index and the one-cycle done pulse aligned with the toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_front     <= 1'b0;
      r_swap_done <= 1'b0;
    end else begin
      r_swap_done <= w_do_swap;
      if (w_do_swap) r_front <= ~r_front;
    end
  end

  assign front_buffer = r_front;
  assign swap_done    = r_swap_done;

  // Out-of-range bit depths fall back to the maximum.
  always_comb begin
    w_bd_eff = ctrl_bitdepth;
    if (ctrl_bitdepth == '0 || ctrl_bitdepth > BD_WIDTH'(BITDEPTH_MAX))
      w_bd_eff = BD_WIDTH'(BITDEPTH_MAX);
  end

  // Read stage 1: carry valid and bit-plane controls alongside the RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe[1] <= 1'b0;
      r_bd_p1       <= '0;
      r_bit_p1      <= '0;
    end else begin
      r_vld_pipe[1] <= r_en;
      r_bd_p1       <= w_bd_eff;
      r_bit_p1      <= r_bit;
    end
  end

  // Field offsets inside the packed pixel: B at 0, G at bd, R at 2*bd.
  always_comb begin
    w_kill  = (BD_WIDTH'(r_bit_p1) >= r_bd_p1);
    w_off_b = IDX_W'(r_bit_p1);
    w_off_g = w_off_b + IDX_W'(r_bd_p1);
    w_off_r = w_off_g + IDX_W'(r_bd_p1);
  end

  assign w_wbank = w_addr >> R_ADDR_WIDTH;

  for (genvar g = 0; g < N_SCAN_GROUPS; g++) begin : g_grp
    logic w_we;
    assign w_we = w_en && (w_wbank == W_ADDR_WIDTH'(g));

    framebuffer_nscan_bank #(
      .AW (R_ADDR_WIDTH + 1),
      .DW (PIX_W)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr ({~r_front, w_addr[R_ADDR_WIDTH-1:0]}),
      .i_wdata (w_din),
      .i_re    (r_en),
      .i_raddr ({r_front, r_addr}),
      .o_rdata (w_rdata[g])
    );

    // Group 0 lands in the MSBs of the output word.
    assign w_sel[3*N_SCAN_GROUPS-1-3*g -: 3] = w_kill ? 3'b000 :
      {w_rdata[g][w_off_r], w_rdata[g][w_off_g], w_rdata[g][w_off_b]};
  end

  // Read stage 2: bit-select register, holds its value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe[2] <= 1'b0;
      r_dout_q      <= '0;
    end else begin
      r_vld_pipe[2] <= r_vld_pipe[1];
      if (r_vld_pipe[1]) r_dout_q <= w_sel;
    end
  end

  assign r_valid = r_vld_pipe[2];
  assign r_dout  = r_dout_q;
endmodule

// File: doc/framebuffer_nscan.md
Name: framebuffer_nscan

Overview:
Single-clock, double-buffered HUB75 framebuffer with N_SCAN_GROUPS parallel row groups. For 1/32-scan 64-row panels N_SCAN_GROUPS=2; other scan ratios use other values.
- Writer always targets the back buffer.
- Scan driver reads bit-planes of the front buffer through a registered 2-cycle pipeline.
- Buffer swap is a request/acknowledge handshake that completes only on a frame boundary.
- Sits between the pixel loader (AXI/SPI side) and the row/column scan controller.

Parameters:
N_ROWS_MAX, 64, total panel rows
N_COLS_MAX, 256, chained columns (panels * cols per panel)
BITDEPTH_MAX, 8, max bits per colour
N_SCAN_GROUPS, 2, rows driven in parallel; power of 2, 1..8
MEM_DEPTH, N_ROWS_MAX*N_COLS_MAX, derived: pixels per buffer
W_ADDR_WIDTH, $clog2(MEM_DEPTH), derived
G_WIDTH, $clog2(N_SCAN_GROUPS), derived (0 when N_SCAN_GROUPS=1)
R_ADDR_WIDTH, W_ADDR_WIDTH-G_WIDTH, derived
BD_WIDTH, $clog2(BITDEPTH_MAX+1), derived

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
w_en  in  1  write strobe
w_addr  in  W_ADDR_WIDTH  row*N_COLS_MAX+col
w_din  in  3*BITDEPTH_MAX  packed pixel {R,G,B}, packing set by ctrl_bitdepth
swap_req  in  1  request buffer swap (1-cycle pulse)
swap_pending  out  1  swap requested, not yet done
swap_done  out  1  1-cycle pulse on the cycle front toggles
front_buffer  out  1  index of buffer currently read
ctrl_bitdepth  in  BD_WIDTH  active bits per colour
r_en  in  1  read request
r_addr  in  R_ADDR_WIDTH  address within a group
r_bit  in  $clog2(BITDEPTH_MAX)  bit-plane to read
r_frame_end  in  1  scanner at frame boundary
r_valid  out  1  r_dout valid
r_dout  out  3*N_SCAN_GROUPS  {R,G,B} per group, group 0 in MSBs

Behaviour:
Reset: front_buffer=0, swap_pending=0, swap_done=0, r_valid=0, r_dout=0, FSM=IDLE. RAM contents are not cleared.

Storage:
- N_SCAN_GROUPS banks, each 2*2^R_ADDR_WIDTH x 3*BITDEPTH_MAX, inferred simple dual-port BRAM.
- Bank address is {buffer, offset}.

Write:
- Bank = w_addr[W_ADDR_WIDTH-1 -: G_WIDTH]; offset = remaining low bits.
- Buffer = ~front_buffer, sampled in the same cycle.
- A write in the swap cycle lands in the pre-swap back buffer, which becomes the new front.

Swap FSM:
- IDLE --swap_req & ~r_frame_end--> PENDING (swap_pending=1).
- IDLE --swap_req & r_frame_end--> swap this cycle.
- PENDING --r_frame_end--> swap, then IDLE.
- Swap action: front_buffer toggles on the next edge, swap_done=1 for exactly 1 cycle, swap_pending clears.
- swap_req while PENDING or in the swap cycle is ignored (no queueing).
- r_frame_end in IDLE without swap_req: no effect.

Read pipeline, latency 2:
- Cycle t: r_en sampled; bank address {front_buffer, r_addr}, buffer bit taken before any swap in cycle t.
- Cycle t+1: RAM output registered.
- Cycle t+2: bit-select register loads; r_valid=1.
- r_valid follows r_en delayed by 2, back-to-back capable.
- r_dout holds its value when r_valid=0.
- Reads in flight during a swap complete from the old buffer.

Bit select, per group g:
- bd = ctrl_bitdepth; bd=0 or bd>BITDEPTH_MAX is treated as BITDEPTH_MAX.
- Field offsets: B at bd*0, G at bd*1, R at bd*2; selected bit = offset + r_bit.
- r_bit >= bd forces that group's 3 bits to 0.
- r_dout[3*N_SCAN_GROUPS-1-3g -: 3] = {R_g, G_g, B_g}.
- ctrl_bitdepth and r_bit are sampled at cycle t and pipelined with the read, so mid-frame changes cannot corrupt in-flight data.

rst mid-operation:
- Aborts PENDING and drops the pipeline (r_valid=0 on the next edge).
- front_buffer returns to 0.

Test Plan:
1. Reset check: assert rst, issue a read with r_en=1 -> two cycles later r_valid=0, r_dout=0, front_buffer=0, swap_pending=0.
2. Write/swap/read: write w_addr=5, w_din=24'hFF0000 with bd=8; pulse swap_req and r_frame_end together -> swap_done 1 cycle and front_buffer=1. Then read r_addr=5, r_bit=7 -> at t+2 r_valid=1, r_dout=6'b100000.
3. Pending swap: swap_req at cycle 10, r_frame_end at cycle 20 -> swap_pending=1 for cycles 11-20, front_buffer toggles at 21. A second swap_req at cycle 15 -> exactly one toggle.
4. Runtime bitdepth: bd=5, w_din=15'b10000_00001_00000 (R=16, G=1, B=0) -> r_bit=4 gives {1,0,0}, r_bit=0 gives {0,1,0}, r_bit=6 gives {0,0,0}.
5. Group mapping, N_SCAN_GROUPS=4, N_ROWS_MAX=64, N_COLS_MAX=64: write pixel R=G=B=8'hFF at row 48, col 3, then swap. Read r_addr=3 -> only r_dout[2:0]=3'b111, all other bits 0.
6. Swap with read in flight: issue r_en at the same cycle as swap_req & r_frame_end -> that read returns old-buffer data, and the read at the next cycle returns new-buffer data.
